sleep_unit_mc: RTL and testbench
================================

Name: sleep_unit_mc

Overview:
Multi-core, parametrised successor of the single-core APB sleep controller. It puts each core of a cluster to sleep independently and wakes it again.
- Per core: a software sleep request, a maskable multi-line wake-event set and an optional timeout counter.
- Per core it drives fetch-enable and clock-gate-enable.
- Sits on the peripheral APB bus next to the event unit, between the event/IRQ sources and the cores' clock gates.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave).
- NB_CORES, 4, number of controlled cores, 1..16.
- NB_EVENTS, 8, number of wake event lines, 1..32.
- TIMER_WIDTH, 16, width of the per-core timeout counter, 1..32.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data (combinational).
- PREADY  out  1  tied 1.
- PSLVERR  out  1  APB error (combinational).
- irq_i  in  NB_CORES  per-core pending interrupt.
- event_i  in  NB_EVENTS  wake event lines, level.
- core_busy_i  in  NB_CORES  per-core busy.
- fetch_en_o  out  NB_CORES  per-core fetch enable, 1 = fetch.
- clk_gate_core_o  out  NB_CORES  per-core clock enable, 1 = clock runs.

Behaviour:
- Reset and clocking: single clock HCLK; HRESET is synchronous active-high.
- Reset values:
  - all FSMs in RUN; all registers 0.
  - fetch_en_o all 1; clk_gate_core_o all 1; PRDATA 0; PSLVERR 0.
- Access: an access is PSEL&&PENABLE. PREADY=1, so every access completes in one cycle.
- Core c register block at offset c*0x10:
  - 0x0 CTRL (RW): bit0 req, bit1 clr_cnt (write-only, reads 0).
  - 0x4 MASK (RW): [NB_EVENTS-1:0] event mask.
  - 0x8 TIMEOUT (RW): [TIMER_WIDTH-1:0]; 0 disables the timeout.
  - 0xC STATUS (RO): [1:0] state, [3:2] last wake cause (0 none, 1 event, 2 timeout), [31:16] wake count (saturates at 0xFFFF).
- Global register 0x100 SLEEPING (RO): bit c = 1 when core c is in SLEEP.
- Address decoding uses PADDR[8:2]. All other addresses read 0.
- PSLVERR=1 for:
  - an access to core index >= NB_CORES;
  - a write to STATUS or SLEEPING;
  - any other unmapped address.
  Such writes have no effect.
- Wake condition: wake_c = |(event_i & MASK_c). It is combinational.
- Per-core FSM, states RUN=0, DRAIN=1, SLEEP=2. Priority within a state: wake > timeout > irq/busy.
  - RUN, req=1, wake_c=1: stay in RUN; clear req; cause=event; wake count +1.
  - RUN, req=1, wake_c=0: go to DRAIN; clear req; load cnt=TIMEOUT.
  - DRAIN, wake_c=1: go to RUN; cause=event.
  - DRAIN, TIMEOUT!=0 and cnt==1: go to RUN; cause=timeout.
  - DRAIN, !core_busy_i[c] && !irq_i[c]: go to SLEEP.
  - SLEEP, wake_c=1: go to RUN; cause=event.
  - SLEEP, timeout as in DRAIN: go to RUN; cause=timeout.
  - SLEEP, irq_i[c]=1: go to DRAIN; cnt keeps counting.
  - Unused state encoding 3: go to RUN.
  - Every transition to RUN increments the wake count.
- Timeout counter: decrements by 1 each cycle in DRAIN or SLEEP while cnt!=0. With TIMEOUT=N, the transition to RUN is taken in the N-th cycle after leaving RUN.
- Outputs (combinational from state, req and wake_c):
  - fetch_en_o[c] = 0 in DRAIN and SLEEP, and in RUN while req && !wake_c; otherwise 1.
  - clk_gate_core_o[c] = 0 only in SLEEP && !wake_c. Wake passes through in the same cycle.
- Writing CTRL.req:
  - Write in cycle t: req is visible at t+1, fetch_en_o drops at t+1, DRAIN is entered at t+2.
  - A write of req while the FSM is not in RUN is ignored.
  - An APB write of req=1 in the same cycle as a hardware clear of req wins.
  - clr_cnt=1 zeroes the wake count. If a wake occurs in the same cycle, the clear wins.
- Writes to MASK or TIMEOUT take effect next cycle. They do not reload a running cnt.
- Reset asserted mid-sleep: at the next edge the core returns to RUN with all outputs at reset values.

Decomposition:
- Shared package sleep_unit_pkg:
  - state encoding (RUN/DRAIN/SLEEP);
  - cause codes;
  - register offsets 0x0/0x4/0x8/0xC/0x100;
  - per-core stride 0x10.
- One sub-module, sleep_core_ctrl: FSM, req/mask/timeout/status registers and counter for one core. It is instantiated NB_CORES times in a generate loop.
- The top level holds the APB decode, the PRDATA/PSLVERR mux and the SLEEPING vector.

Test Plan:
- Basic sleep and event wake:
  - Stimulus: core0 MASK=0x01, write CTRL=1, busy=0, irq=0.
  - Response: fetch_en_o[0]=0 at t+1; DRAIN at t+2; SLEEP and clk_gate_core_o[0]=0 at t+3. Raise event_i[0]: clk_gate_core_o[0]=1 in the same cycle, RUN next cycle, STATUS=0x00010004.
- Masked event:
  - Stimulus: MASK=0x02 with event_i[0] pulsed while core0 sleeps.
  - Response: core stays in SLEEP. event_i[1] wakes it.
- Timeout:
  - Stimulus: TIMEOUT=5, no events.
  - Response: core returns to RUN in the 5th cycle after leaving RUN, cause=2, wake count increments.
- IRQ handling:
  - Stimulus: busy=1 holds core in DRAIN; busy drops so core enters SLEEP; then irq_i[0]=1.
  - Response: DRAIN, clk_gate_core_o[0]=1, fetch_en_o[0]=0. irq drops: back to SLEEP.
- Multi-core independence:
  - Stimulus: cores 0 and 2 sleep, core 1 runs.
  - Response: SLEEPING=0x5. Waking core 2 gives SLEEPING=0x1.
- APB errors and resets:
  - Stimulus: access to 0x40 with NB_CORES=4, and a write to 0x0C.
  - Response: PSLVERR=1, no state change.
  - Stimulus: HRESET pulsed during SLEEP.
  - Response: all outputs 1 and all registers 0 after the next edge.

Source files
------------

// File: rtl/sleep_unit_pkg.sv
// Shared definitions for the multi-core sleep unit: per-core FSM state
// encoding, wake-cause codes and the APB register map.
package sleep_unit_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_SLEEP = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EVENT   = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   localparam logic [8:0] OFF_CTRL     = 9'h000;
   localparam logic [8:0] OFF_MASK     = 9'h004;
   localparam logic [8:0] OFF_TIMEOUT  = 9'h008;
   localparam logic [8:0] OFF_STATUS   = 9'h00C;
   localparam logic [8:0] OFF_SLEEPING = 9'h100;

   localparam logic [8:0] CORE_STRIDE = 9'h010;
   localparam int         CORE_SHIFT  = $clog2(CORE_STRIDE);

   // register select within a core block (word index inside the stride)
   function automatic logic [1:0] reg_sel_of(input logic [8:0] off);
      return off[3:2];
   endfunction

endpackage

// File: rtl/sleep_core_ctrl.sv
// Sleep controller for a single core: CTRL/MASK/TIMEOUT/STATUS registers,
// wake-event masking, timeout down-counter and the RUN/DRAIN/SLEEP FSM.
//
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   wr_ctrl/wr_mask/wr_timeout  one-cycle write strobes from the APB decode
//   wr_data                APB write data
//   reg_sel                register selected for read-back
//   irq, core_busy         core status inputs
//   event_lines            raw wake event lines
//   rd_data                read-back of the selected register
//   sleeping               1 while in SLEEP
//   fetch_en, clk_gate     core fetch enable / clock enable
//
// state | meaning
// RUN   | core fetching; a pending req starts the sleep sequence
// DRAIN | fetch stopped, waiting for core idle and no irq
// SLEEP | clock gated until a wake event or timeout; irq goes back to DRAIN
module sleep_core_ctrl
   import sleep_unit_pkg::*;
#(
   parameter int NB_EVENTS   = 8,
   parameter int TIMER_WIDTH = 16
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 wr_ctrl,
   input  logic                 wr_mask,
   input  logic                 wr_timeout,
   input  logic [31:0]          wr_data,
   input  logic [1:0]           reg_sel,
   input  logic                 irq,
   input  logic                 core_busy,
   input  logic [NB_EVENTS-1:0] event_lines,
   output logic [31:0]          rd_data,
   output logic                 sleeping,
   output logic                 fetch_en,
   output logic                 clk_gate
);

   logic [1:0]             state_q, state_d;
   logic [1:0]             cause_q, cause_d;
   logic                   req_q;
   logic [NB_EVENTS-1:0]   mask_q;
   logic [TIMER_WIDTH-1:0] timeout_q, cnt_q;
   logic [15:0]            wcnt_q;
   logic                   wake, timeout_hit, req_clr, load_cnt, woke;
   logic                   unused_wdata;

   assign unused_wdata = ^wr_data;
   assign wake         = |(event_lines & mask_q);
   assign timeout_hit  = (timeout_q != '0) && (cnt_q == TIMER_WIDTH'(1));

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      req_clr  = 1'b0;
      load_cnt = 1'b0;
      woke     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (req_q) begin
               req_clr = 1'b1;
               if (wake) begin
                  woke    = 1'b1;
                  cause_d = CAUSE_EVENT;
               end else begin
                  state_d  = ST_DRAIN;
                  load_cnt = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (wake) begin
               state_d = ST_RUN;
               cause_d = CAUSE_EVENT;
               woke    = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_RUN;
               cause_d = CAUSE_TIMEOUT;
               woke    = 1'b1;
            end else if (!core_busy && !irq) begin
               state_d = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            if (wake) begin
               state_d = ST_RUN;
               cause_d = CAUSE_EVENT;
               woke    = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_RUN;
               cause_d = CAUSE_TIMEOUT;
               woke    = 1'b1;
            end else if (irq) begin
               state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= ST_RUN;
         cause_q   <= CAUSE_NONE;
         req_q     <= 1'b0;
         mask_q    <= '0;
         timeout_q <= '0;
         cnt_q     <= '0;
         wcnt_q    <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         // software write of req beats the hardware clear in the same cycle
         if (wr_ctrl && (state_q == ST_RUN)) req_q <= wr_data[0];
         else if (req_clr)                   req_q <= 1'b0;
         if (wr_mask)    mask_q    <= wr_data[NB_EVENTS-1:0];
         if (wr_timeout) timeout_q <= wr_data[TIMER_WIDTH-1:0];
         if (load_cnt)
            cnt_q <= timeout_q;
         else if (((state_q == ST_DRAIN) || (state_q == ST_SLEEP)) && (cnt_q != '0))
            cnt_q <= cnt_q - TIMER_WIDTH'(1);
         if (wr_ctrl && wr_data[1])          wcnt_q <= '0;
         else if (woke && (wcnt_q != 16'hFFFF)) wcnt_q <= wcnt_q + 16'd1;
      end
   end

   assign sleeping = (state_q == ST_SLEEP);
   assign fetch_en = !((state_q == ST_DRAIN) || (state_q == ST_SLEEP) ||
                       ((state_q == ST_RUN) && req_q && !wake));
   assign clk_gate = !((state_q == ST_SLEEP) && !wake);

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         reg_sel_of(OFF_CTRL):    rd_data[0] = req_q;
         reg_sel_of(OFF_MASK):    rd_data[NB_EVENTS-1:0] = mask_q;
         reg_sel_of(OFF_TIMEOUT): rd_data[TIMER_WIDTH-1:0] = timeout_q;
         default:                 rd_data = {wcnt_q, 12'd0, cause_q, state_q};
      endcase
   end

endmodule

// File: rtl/sleep_unit_mc.sv
// Multi-core APB sleep unit: decodes the APB register map, fans writes out
// to one sleep_core_ctrl per core and muxes read data / slave errors.
//
// Ports:
//   HCLK, HRESET                     clock, synchronous active-high reset
//   PADDR..PENABLE, PRDATA, PREADY, PSLVERR   APB slave (zero wait states)
//   irq_i, core_busy_i               per-core status
//   event_i                          wake event lines (level)
//   fetch_en_o, clk_gate_core_o      per-core fetch and clock enables
module sleep_unit_mc
   import sleep_unit_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NB_CORES       = 4,
   parameter int NB_EVENTS      = 8,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [NB_CORES-1:0]       irq_i,
   input  logic [NB_EVENTS-1:0]      event_i,
   input  logic [NB_CORES-1:0]       core_busy_i,
   output logic [NB_CORES-1:0]       fetch_en_o,
   output logic [NB_CORES-1:0]       clk_gate_core_o
);

   logic                access, is_core, core_ok, is_sleeping_reg, addr_err, wr_ok;
   logic [3:0]          core_idx;
   logic [1:0]          reg_sel;
   logic [NB_CORES-1:0] sleeping;
   logic [31:0]         core_rd [NB_CORES];
   logic                unused_paddr;

   // only PADDR[8:2] takes part in decoding
   assign unused_paddr    = ^PADDR;
   assign access          = PSEL & PENABLE;
   assign core_idx        = PADDR[CORE_SHIFT+3:CORE_SHIFT];
   assign reg_sel         = PADDR[3:2];
   assign is_core         = !PADDR[8];
   assign core_ok         = is_core && (int'(core_idx) < NB_CORES);
   assign is_sleeping_reg = (PADDR[8:2] == OFF_SLEEPING[8:2]);

   always_comb begin
      if (is_core) addr_err = !core_ok || (PWRITE && (reg_sel == reg_sel_of(OFF_STATUS)));
      else         addr_err = !is_sleeping_reg || PWRITE;
   end

   assign PSLVERR = access && addr_err;
   assign PREADY  = 1'b1;
   assign wr_ok   = access && PWRITE && !addr_err;

   for (genvar c = 0; c < NB_CORES; c++) begin : g_core
      logic wr_core;
      assign wr_core = wr_ok && is_core && (core_idx == 4'(c));
      sleep_core_ctrl #(
         .NB_EVENTS   (NB_EVENTS),
         .TIMER_WIDTH (TIMER_WIDTH)
      ) u_core (
         .HCLK        (HCLK),
         .HRESET      (HRESET),
         .wr_ctrl     (wr_core && (reg_sel == reg_sel_of(OFF_CTRL))),
         .wr_mask     (wr_core && (reg_sel == reg_sel_of(OFF_MASK))),
         .wr_timeout  (wr_core && (reg_sel == reg_sel_of(OFF_TIMEOUT))),
         .wr_data     (PWDATA),
         .reg_sel     (reg_sel),
         .irq         (irq_i[c]),
         .core_busy   (core_busy_i[c]),
         .event_lines (event_i),
         .rd_data     (core_rd[c]),
         .sleeping    (sleeping[c]),
         .fetch_en    (fetch_en_o[c]),
         .clk_gate    (clk_gate_core_o[c])
      );
   end

   always_comb begin
      PRDATA = '0;
      if (access && !PWRITE && !addr_err) begin
         if (is_core) begin
            for (int c = 0; c < NB_CORES; c++)
               if (core_idx == 4'(c)) PRDATA = core_rd[c];
         end else begin
            PRDATA[NB_CORES-1:0] = sleeping;
         end
      end
   end

endmodule

// File: tb/tb_sleep_unit_mc.sv
module tb_sleep_unit_mc;

   localparam int NC = 4;
   localparam int NE = 8;
   localparam int TW = 16;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [11:0]   PADDR;
   logic [31:0]   PWDATA, PRDATA;
   logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [NC-1:0] irq_i, core_busy_i, fetch_en_o, clk_gate_core_o;
   logic [NE-1:0] event_i;

   int errors = 0;
   int checks = 0;

   // reference model: what software has programmed and what wakes have happened
   int            exp_wcnt  [NC];
   int            exp_cause [NC];
   logic [NE-1:0] exp_mask  [NC];
   logic [TW-1:0] exp_tmo   [NC];

   sleep_unit_mc #(.APB_ADDR_WIDTH(12), .NB_CORES(NC), .NB_EVENTS(NE), .TIMER_WIDTH(TW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .irq_i(irq_i), .event_i(event_i), .core_busy_i(core_busy_i),
      .fetch_en_o(fetch_en_o), .clk_gate_core_o(clk_gate_core_o));

   always #5 HCLK = ~HCLK;

   task automatic step();
      @(posedge HCLK); #1;
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
      step();
      PENABLE = 1; #1 err = PSLVERR;
      step();
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
      step();
      PENABLE = 1; #1 d = PRDATA; err = PSLVERR;
      step();
      PSEL = 0; PENABLE = 0;
   endtask

   function automatic logic [31:0] exp_status(input int c, input logic [1:0] st);
      return {16'(exp_wcnt[c]), 12'd0, 2'(exp_cause[c]), st};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         exp_wcnt[c] = 0; exp_cause[c] = 0; exp_mask[c] = '0; exp_tmo[c] = '0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic e;
      HRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      irq_i = '0; core_busy_i = '0; event_i = '0;
      model_reset();
      repeat (3) step();
      checks++; if (fetch_en_o !== 4'hF) begin errors++; $display("FAIL rst_fetch got %h exp %h", fetch_en_o, 4'hF); end
      checks++; if (clk_gate_core_o !== 4'hF) begin errors++; $display("FAIL rst_gate got %h exp %h", clk_gate_core_o, 4'hF); end
      checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h exp 0", PRDATA); end
      checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr got %b exp 0", PSLVERR); end
      HRESET = 0;
      step();
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < 4; r++) begin
            apb_read(12'(c * 16 + r * 4), d, e);
            checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rst_reg c%0d r%0d got %h err %b exp 0", c, r, d, e); end
         end
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_sleeping got %h exp 0", d); end
   endtask

   task automatic test_event_wake();
      logic [31:0] d; logic e;
      apb_write(12'h004, 32'h1, e); exp_mask[0] = 8'h01;
      apb_write(12'h000, 32'h1, e);
      #1;
      checks++; if (fetch_en_o[0] !== 1'b0) begin errors++; $display("FAIL evt_fetch_t1 got %b exp 0", fetch_en_o[0]); end
      step();
      checks++; if (clk_gate_core_o[0] !== 1'b1 || fetch_en_o[0] !== 1'b0) begin errors++; $display("FAIL evt_drain_t2 gate %b fetch %b exp 1/0", clk_gate_core_o[0], fetch_en_o[0]); end
      step();
      checks++; if (clk_gate_core_o[0] !== 1'b0) begin errors++; $display("FAIL evt_sleep_t3 got %b exp 0", clk_gate_core_o[0]); end
      event_i = 8'h01; #1;
      checks++; if (clk_gate_core_o[0] !== 1'b1) begin errors++; $display("FAIL evt_gate_pass got %b exp 1", clk_gate_core_o[0]); end
      step(); event_i = '0; #1;
      exp_wcnt[0]++; exp_cause[0] = 1;
      checks++; if (fetch_en_o[0] !== 1'b1) begin errors++; $display("FAIL evt_run got %b exp 1", fetch_en_o[0]); end
      apb_read(12'h00C, d, e);
      checks++; if (d !== 32'h00010004) begin errors++; $display("FAIL evt_status got %h exp %h", d, 32'h00010004); end
   endtask

   task automatic test_masked_event();
      logic [31:0] d; logic e; int m; logic [NE-1:0] other, mbit;
      m = $urandom_range(0, NE - 1);
      mbit = NE'(1) << m;
      other = NE'($urandom) & ~mbit;
      if (other == '0) other = NE'(1) << ((m + 1) % NE);
      apb_write(12'h004, 32'(mbit), e); exp_mask[0] = mbit;
      apb_write(12'h000, 32'h1, e);
      step(); step();
      event_i = other; #1;
      checks++; if (clk_gate_core_o[0] !== 1'b0) begin errors++; $display("FAIL mask_blocked ev %h got %b exp 0", other, clk_gate_core_o[0]); end
      step(); event_i = '0; step();
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_still_sleep got %h exp 1", d); end
      event_i = mbit; #1;
      checks++; if (clk_gate_core_o[0] !== 1'b1) begin errors++; $display("FAIL mask_wake_gate got %b exp 1", clk_gate_core_o[0]); end
      step(); event_i = '0; #1;
      exp_wcnt[0]++; exp_cause[0] = 1;
      apb_read(12'h00C, d, e);
      checks++; if (d !== exp_status(0, 2'd0)) begin errors++; $display("FAIL mask_status got %h exp %h", d, exp_status(0, 2'd0)); end
   endtask

   task automatic test_timeout();
      logic [31:0] d; logic e; int n, zeros;
      apb_write(12'h004, 32'h0, e); exp_mask[0] = '0;
      for (int it = 0; it < 3; it++) begin
         n = (it == 0) ? 1 : $urandom_range(2, 20);
         apb_write(12'h008, 32'(n), e);
         apb_write(12'h000, 32'h1, e);
         zeros = 0;
         while (fetch_en_o[0] === 1'b0 && zeros < 200) begin zeros++; step(); end
         // fetch is low from the req-visible cycle through the N-th non-RUN cycle
         checks++; if (zeros != n + 1) begin errors++; $display("FAIL tmo_cycles n=%0d got %0d exp %0d", n, zeros, n + 1); end
         exp_wcnt[0]++; exp_cause[0] = 2;
         apb_read(12'h00C, d, e);
         checks++; if (d !== exp_status(0, 2'd0)) begin errors++; $display("FAIL tmo_status n=%0d got %h exp %h", n, d, exp_status(0, 2'd0)); end
      end
      apb_write(12'h008, 32'h0, e);
   endtask

   task automatic test_irq();
      logic [31:0] d; logic e;
      apb_write(12'h004, 32'h1, e); exp_mask[0] = 8'h01;
      core_busy_i[0] = 1;
      apb_write(12'h000, 32'h1, e);
      repeat (4) step();
      checks++; if (fetch_en_o[0] !== 1'b0 || clk_gate_core_o[0] !== 1'b1) begin errors++; $display("FAIL irq_busy_drain fetch %b gate %b exp 0/1", fetch_en_o[0], clk_gate_core_o[0]); end
      core_busy_i[0] = 0; step();
      checks++; if (clk_gate_core_o[0] !== 1'b0) begin errors++; $display("FAIL irq_sleep got %b exp 0", clk_gate_core_o[0]); end
      irq_i[0] = 1; step();
      checks++; if (clk_gate_core_o[0] !== 1'b1 || fetch_en_o[0] !== 1'b0) begin errors++; $display("FAIL irq_drain gate %b fetch %b exp 1/0", clk_gate_core_o[0], fetch_en_o[0]); end
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_sleeping got %h exp 0", d); end
      irq_i[0] = 0; step();
      checks++; if (clk_gate_core_o[0] !== 1'b0) begin errors++; $display("FAIL irq_resleep got %b exp 0", clk_gate_core_o[0]); end
      apb_write(12'h000, 32'h1, e);
      event_i = 8'h01; step(); event_i = '0; #1;
      exp_wcnt[0]++; exp_cause[0] = 1;
      checks++; if (fetch_en_o[0] !== 1'b1) begin errors++; $display("FAIL irq_wake got %b exp 1", fetch_en_o[0]); end
      step(); step();
      checks++; if (fetch_en_o[0] !== 1'b1) begin errors++; $display("FAIL irq_req_ignored got %b exp 1", fetch_en_o[0]); end
      apb_read(12'h000, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_ctrl got %h exp 0", d); end
   endtask

   task automatic test_multi_core();
      logic [31:0] d; logic e;
      for (int c = 0; c < NC; c++) begin
         apb_write(12'(c * 16 + 4), 32'(1 << c), e); exp_mask[c] = NE'(1 << c);
      end
      apb_write(12'h000, 32'h1, e);
      apb_write(12'h020, 32'h1, e);
      repeat (3) step();
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h5) begin errors++; $display("FAIL mc_sleeping got %h exp 5", d); end
      checks++; if (fetch_en_o !== 4'b1010 || clk_gate_core_o !== 4'b1010) begin errors++; $display("FAIL mc_outputs fetch %b gate %b exp 1010", fetch_en_o, clk_gate_core_o); end
      event_i = 8'h04; step(); event_i = '0;
      exp_wcnt[2]++; exp_cause[2] = 1;
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL mc_sleeping2 got %h exp 1", d); end
      checks++; if (fetch_en_o !== 4'b1110) begin errors++; $display("FAIL mc_fetch2 got %b exp 1110", fetch_en_o); end
      event_i = 8'h01; step(); event_i = '0;
      exp_wcnt[0]++; exp_cause[0] = 1;
      apb_read(12'h02C, d, e);
      checks++; if (d !== exp_status(2, 2'd0)) begin errors++; $display("FAIL mc_status2 got %h exp %h", d, exp_status(2, 2'd0)); end
   endtask

   task automatic test_clr_cnt();
      logic [31:0] d; logic e;
      event_i = 8'h01;
      apb_write(12'h000, 32'h1, e); #1;
      checks++; if (fetch_en_o[0] !== 1'b1) begin errors++; $display("FAIL runwake_fetch got %b exp 1", fetch_en_o[0]); end
      step(); event_i = '0;
      exp_wcnt[0]++; exp_cause[0] = 1;
      apb_read(12'h00C, d, e);
      checks++; if (d !== exp_status(0, 2'd0)) begin errors++; $display("FAIL runwake_status got %h exp %h", d, exp_status(0, 2'd0)); end
      apb_write(12'h000, 32'h1, e);
      step(); step();
      checks++; if (clk_gate_core_o[0] !== 1'b0) begin errors++; $display("FAIL clr_sleep got %b exp 0", clk_gate_core_o[0]); end
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h000; PWDATA = 32'h2;
      step();
      PENABLE = 1; event_i = 8'h01;
      step();
      PSEL = 0; PENABLE = 0; PWRITE = 0; event_i = '0;
      exp_wcnt[0] = 0; exp_cause[0] = 1;
      apb_read(12'h00C, d, e);
      checks++; if (d !== exp_status(0, 2'd0)) begin errors++; $display("FAIL clr_vs_wake got %h exp %h", d, exp_status(0, 2'd0)); end
      apb_read(12'h000, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_ctrl_read got %h exp 0", d); end
   endtask

   task automatic test_apb_errors();
      logic [31:0] d, v, exp_d; logic e; int c, r;
      apb_write(12'h040, $urandom, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_core4 got %b exp 1", e); end
      apb_read(12'h044, d, e);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_rd_core4 err %b data %h exp 1/0", e, d); end
      apb_write(12'h00C, 32'hFFFF_FFFF, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_status got %b exp 1", e); end
      apb_write(12'h100, 32'hF, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_sleeping got %b exp 1", e); end
      apb_read(12'h104, d, e);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_rd_unmapped err %b data %h exp 1/0", e, d); end
      apb_read(12'h00C, d, e);
      checks++; if (d !== exp_status(0, 2'd0) || e !== 1'b0) begin errors++; $display("FAIL err_no_effect got %h exp %h", d, exp_status(0, 2'd0)); end
      apb_read(12'h004, d, e);
      checks++; if (d !== 32'(exp_mask[0])) begin errors++; $display("FAIL err_mask_kept got %h exp %h", d, exp_mask[0]); end
      for (int i = 0; i < 10; i++) begin
         c = $urandom_range(0, NC - 1);
         r = $urandom_range(1, 2);
         v = $urandom;
         apb_write(12'(c * 16 + r * 4), v, e);
         if (r == 1) exp_mask[c] = v[NE-1:0]; else exp_tmo[c] = v[TW-1:0];
         c = $urandom_range(0, NC - 1);
         r = $urandom_range(0, 3);
         apb_read(12'(c * 16 + r * 4), d, e);
         case (r)
            0: exp_d = 32'h0;
            1: exp_d = 32'(exp_mask[c]);
            2: exp_d = 32'(exp_tmo[c]);
            default: exp_d = exp_status(c, 2'd0);
         endcase
         checks++; if (d !== exp_d || e !== 1'b0) begin errors++; $display("FAIL regs c%0d r%0d got %h err %b exp %h", c, r, d, e, exp_d); end
      end
   endtask

   task automatic test_reset_mid_sleep();
      logic [31:0] d; logic e;
      apb_write(12'h004, 32'h1, e);
      apb_write(12'h014, 32'h2, e);
      apb_write(12'h008, 32'd50, e);
      apb_write(12'h018, 32'h0, e);
      apb_write(12'h000, 32'h1, e);
      apb_write(12'h010, 32'h1, e);
      repeat (3) step();
      checks++; if (clk_gate_core_o[1:0] !== 2'b00) begin errors++; $display("FAIL rms_asleep got %b exp 00", clk_gate_core_o[1:0]); end
      HRESET = 1; step();
      checks++; if (fetch_en_o !== 4'hF || clk_gate_core_o !== 4'hF) begin errors++; $display("FAIL rms_outputs fetch %h gate %h exp F/F", fetch_en_o, clk_gate_core_o); end
      HRESET = 0; model_reset();
      apb_read(12'h100, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rms_sleeping got %h exp 0", d); end
      for (int r = 0; r < 4; r++) begin
         apb_read(12'(r * 4), d, e);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL rms_reg r%0d got %h exp 0", r, d); end
      end
      apb_read(12'h014, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rms_mask1 got %h exp 0", d); end
   endtask

   initial begin
      test_reset();
      test_event_wake();
      test_masked_event();
      test_timeout();
      test_irq();
      test_multi_core();
      test_clr_cnt();
      test_apb_errors();
      test_reset_mid_sleep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
